// File: rtl/microc_run_ctrl_pkg.sv
// Shared constants and types for the microc sequencing controller:
// opcode classes, control sub-ops, ALU codes and run-control state encoding.
package microc_run_ctrl_pkg;

    localparam logic [1:0] CLS_CTRL = 2'b00;
    localparam logic [1:0] CLS_REG  = 2'b01;
    localparam logic [1:0] CLS_IMM  = 2'b10;
    localparam logic [1:0] CLS_ILL  = 2'b11;

    localparam logic [3:0] OP_J   = 4'b0000;
    localparam logic [3:0] OP_JZ  = 4'b0001;
    localparam logic [3:0] OP_JNZ = 4'b0010;
    localparam logic [3:0] OP_NOP = 4'b0011;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } run_state_e;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
    } ctrl_word_t;

    // Safe word: no writes, PC would advance by one (but pc_en gates it).
    localparam ctrl_word_t CTRL_SAFE = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0,
                                         wez: 1'b0, alu_op: ALU_PASS};

endpackage

// File: rtl/microc_run_ctrl_decode.sv
// Combinational opcode/zero-flag decoder producing the microc control word
// and an illegal-opcode indication.
module uc_decode
    import microc_run_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic       z_i,
    output ctrl_word_t ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_SAFE;
        illegal_o = 1'b0;
        case (opcode_i[5:4])
            CLS_REG: begin
                ctrl_o.alu_op = opcode_i[2:0];
                ctrl_o.we     = 1'b1;
                ctrl_o.wez    = 1'b1;
            end
            CLS_IMM: begin
                ctrl_o.alu_op = opcode_i[2:0];
                ctrl_o.we     = 1'b1;
                ctrl_o.s_inm  = 1'b1;
                // li only loads a register; it must not disturb the zero flag
                ctrl_o.wez    = (opcode_i[2:0] != ALU_PASS);
            end
            CLS_CTRL: begin
                case (opcode_i[3:0])
                    OP_J:    ctrl_o.s_inc = 1'b0;
                    OP_JZ:   ctrl_o.s_inc = ~z_i;
                    OP_JNZ:  ctrl_o.s_inc = z_i;
                    OP_NOP:  ctrl_o.s_inc = 1'b1;
                    default: illegal_o    = 1'b1;
                endcase
            end
            CLS_ILL:  illegal_o = 1'b1;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/microc_run_ctrl.sv
// Run-control sequencer for the microc datapath: gates decoded control with an
// idle/run/step/halt FSM and counts retired instructions.
//
// state | meaning
// IDLE  | after reset, core parked, waiting for start/step
// RUN   | free-running, one instruction per cycle
// STEP  | executing exactly one instruction, then HALT
// HALT  | stopped by halt_req, single-step or illegal opcode
module microc_run_ctrl
    import microc_run_ctrl_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             running,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    run_state_e       state_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    ctrl_word_t dec_word;
    ctrl_word_t out_word;
    logic       dec_illegal;
    logic       exec;
    logic       stop_ill;

    uc_decode u_decode (
        .opcode_i  (Opcode),
        .z_i       (z),
        .ctrl_o    (dec_word),
        .illegal_o (dec_illegal)
    );

    assign exec     = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign stop_ill = dec_illegal && HALT_ON_ILLEGAL;

    always_comb begin
        out_word = CTRL_SAFE;
        pc_en    = 1'b0;
        if (exec && !stop_ill) begin
            pc_en = 1'b1;
            // with halting disabled an illegal opcode retires as a nop
            out_word = dec_illegal ? CTRL_SAFE : dec_word;
        end
    end

    assign s_inc = out_word.s_inc;
    assign s_inm = out_word.s_inm;
    assign we    = out_word.we;
    assign wez   = out_word.wez;
    assign ALUOp = out_word.alu_op;

    assign cnt_d = (pc_en && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        illegal_q <= 1'b0;
                    end else if (step) begin
                        state_q <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (stop_ill) begin
                        state_q   <= ST_HALT;
                        illegal_q <= 1'b1;
                    end else if (halt_req) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_HALT;
                    if (stop_ill) begin
                        illegal_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign running     = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT);
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_microc_run_ctrl.sv
// Scoreboard bench for microc_run_ctrl: directed cycles push expectations,
// a monitor pops and compares them a few ns after each falling edge.
module tb_microc_run_ctrl;
    import microc_run_ctrl_pkg::*;

    logic       clk;
    logic       reset, start, step, halt_req, z;
    logic [5:0] Opcode;

    logic        s_inc, s_inm, we, wez, pc_en, running, halted, illegal;
    logic [2:0]  ALUOp;
    logic [15:0] instr_count;

    logic        c4_s_inc, c4_s_inm, c4_we, c4_wez, c4_pc_en, c4_running, c4_halted, c4_illegal;
    logic [2:0]  c4_alu;
    logic [3:0]  c4_cnt;

    logic        nh_s_inc, nh_s_inm, nh_we, nh_wez, nh_pc_en, nh_running, nh_halted, nh_illegal;
    logic [2:0]  nh_alu;
    logic [15:0] nh_cnt;

    microc_run_ctrl u_dut (
        .clk(clk), .reset(reset), .start(start), .step(step), .halt_req(halt_req),
        .Opcode(Opcode), .z(z), .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez),
        .ALUOp(ALUOp), .pc_en(pc_en), .running(running), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    microc_run_ctrl #(.CNT_W(4)) u_c4 (
        .clk(clk), .reset(reset), .start(start), .step(step), .halt_req(halt_req),
        .Opcode(Opcode), .z(z), .s_inc(c4_s_inc), .s_inm(c4_s_inm), .we(c4_we), .wez(c4_wez),
        .ALUOp(c4_alu), .pc_en(c4_pc_en), .running(c4_running), .halted(c4_halted),
        .illegal(c4_illegal), .instr_count(c4_cnt)
    );

    microc_run_ctrl #(.HALT_ON_ILLEGAL(1'b0)) u_nh (
        .clk(clk), .reset(reset), .start(start), .step(step), .halt_req(halt_req),
        .Opcode(Opcode), .z(z), .s_inc(nh_s_inc), .s_inm(nh_s_inm), .we(nh_we), .wez(nh_wez),
        .ALUOp(nh_alu), .pc_en(nh_pc_en), .running(nh_running), .halted(nh_halted),
        .illegal(nh_illegal), .instr_count(nh_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -1 in any field means "don't care" for that cycle
    typedef struct {
        string name;
        int s_inc, s_inm, we, wez, alu, pc_en;
        int running, halted, illegal, cnt;
        int cnt4, nh_pc_en, nh_running;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t ex(input string n);
        exp_t e;
        e.name = n;
        e.s_inc = -1; e.s_inm = -1; e.we = -1; e.wez = -1; e.alu = -1; e.pc_en = -1;
        e.running = -1; e.halted = -1; e.illegal = -1; e.cnt = -1;
        e.cnt4 = -1; e.nh_pc_en = -1; e.nh_running = -1;
        return e;
    endfunction

    function automatic exp_t ctl(input exp_t e, input int si, input int sm, input int w,
                                 input int wz, input int alu, input int pe);
        exp_t r = e;
        r.s_inc = si; r.s_inm = sm; r.we = w; r.wez = wz; r.alu = alu; r.pc_en = pe;
        return r;
    endfunction

    function automatic exp_t st(input exp_t e, input int run, input int hlt,
                                input int ill, input int cnt);
        exp_t r = e;
        r.running = run; r.halted = hlt; r.illegal = ill; r.cnt = cnt;
        return r;
    endfunction

    function automatic exp_t idle_ctl(input exp_t e);
        return ctl(e, 1, 0, 0, 0, int'(ALU_PASS), 0);
    endfunction

    task automatic cyc(input logic r, input logic sa, input logic sp, input logic hr,
                       input logic [5:0] op, input logic zz, input exp_t e);
        @(negedge clk);
        reset = r; start = sa; step = sp; halt_req = hr; Opcode = op; z = zz;
        sb.push_back(e);
    endtask

    function automatic void cmpf(input string f, input int e, input int a,
                                 inout bit bad, inout string msg);
        if (e >= 0 && e != a) begin
            bad = 1'b1;
            msg = {msg, $sformatf(" %s got %0d want %0d", f, a, e)};
        end
    endfunction

    initial begin : monitor
        exp_t  e;
        bit    bad;
        string msg;
        forever begin
            @(negedge clk);
            #3;
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                bad = 1'b0;
                msg = "";
                cmpf("s_inc", e.s_inc, int'(s_inc), bad, msg);
                cmpf("s_inm", e.s_inm, int'(s_inm), bad, msg);
                cmpf("we", e.we, int'(we), bad, msg);
                cmpf("wez", e.wez, int'(wez), bad, msg);
                cmpf("ALUOp", e.alu, int'(ALUOp), bad, msg);
                cmpf("pc_en", e.pc_en, int'(pc_en), bad, msg);
                cmpf("running", e.running, int'(running), bad, msg);
                cmpf("halted", e.halted, int'(halted), bad, msg);
                cmpf("illegal", e.illegal, int'(illegal), bad, msg);
                cmpf("instr_count", e.cnt, int'(instr_count), bad, msg);
                cmpf("cnt_w4", e.cnt4, int'(c4_cnt), bad, msg);
                cmpf("nohalt_pc_en", e.nh_pc_en, int'(nh_pc_en), bad, msg);
                cmpf("nohalt_running", e.nh_running, int'(nh_running), bad, msg);
                n_tests++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s:%s", e.name, msg);
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        reset = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0; z = 1'b0;
        Opcode = 6'b100000;

        // reset then idle with li presented
        cyc(1, 0, 0, 0, 6'b100000, 0, ex("reset_cycle"));
        for (int i = 0; i < 4; i++) begin
            e = st(idle_ctl(ex("idle_after_reset")), 0, 0, 0, 0);
            e.cnt4 = 0;
            cyc(0, 0, 0, 0, 6'b100000, 0, e);
        end

        // start, li then sub
        cyc(0, 1, 0, 0, 6'b100000, 0, st(idle_ctl(ex("start_idle_cycle")), 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'b100000, 0, st(ctl(ex("run_li"), 1, 1, 1, 0, int'(ALU_PASS), 1), 1, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'b010011, 0, st(ctl(ex("run_sub"), 1, 0, 1, 1, int'(ALU_SUB), 1), 1, 0, 0, 1));

        // branches
        cyc(0, 0, 0, 0, 6'b000010, 0, st(ctl(ex("jnz_z0"), 0, 0, 0, 0, 0, 1), 1, 0, 0, 2));
        cyc(0, 0, 0, 0, 6'b000010, 1, st(ctl(ex("jnz_z1"), 1, 0, 0, 0, 0, 1), 1, 0, 0, 3));
        cyc(0, 0, 0, 0, 6'b000001, 1, st(ctl(ex("jz_z1"), 0, 0, 0, 0, 0, 1), 1, 0, 0, 4));
        cyc(0, 0, 0, 0, 6'b000000, 0, st(ctl(ex("j"), 0, 0, 0, 0, 0, 1), 1, 0, 0, 5));
        cyc(0, 0, 0, 0, 6'b000011, 0, st(ctl(ex("nop"), 1, 0, 0, 0, 0, 1), 1, 0, 0, 6));
        cyc(0, 0, 0, 0, 6'b000001, 0, st(ctl(ex("jz_z0"), 1, 0, 0, 0, 0, 1), 1, 0, 0, 7));

        // halt_req: instruction still retires
        cyc(0, 0, 0, 1, 6'b000011, 0, st(ctl(ex("halt_req_exec"), 1, 0, 0, 0, 0, 1), 1, 0, 0, 8));
        cyc(0, 0, 0, 0, 6'b100010, 0, st(idle_ctl(ex("halted_holds")), 0, 1, 0, 9));

        // single step of addi
        cyc(0, 0, 1, 0, 6'b100010, 0, st(idle_ctl(ex("step_req")), 0, 1, 0, 9));
        cyc(0, 0, 0, 0, 6'b100010, 0, st(ctl(ex("step_addi"), 1, 1, 1, 1, int'(ALU_ADD), 1), 0, 0, 0, 9));
        cyc(0, 0, 0, 0, 6'b100010, 0, st(idle_ctl(ex("after_step")), 0, 1, 0, 10));
        cyc(0, 0, 0, 0, 6'b100010, 0, st(idle_ctl(ex("after_step2")), 0, 1, 0, 10));

        // held step: one instruction every two cycles
        cyc(0, 0, 1, 0, 6'b010100, 0, st(idle_ctl(ex("held_step_h0")), 0, 1, 0, 10));
        cyc(0, 0, 1, 0, 6'b010100, 0, st(ctl(ex("held_step_x0"), 1, 0, 1, 1, int'(ALU_AND), 1), 0, 0, 0, 10));
        cyc(0, 0, 1, 0, 6'b010100, 0, st(idle_ctl(ex("held_step_h1")), 0, 1, 0, 11));
        cyc(0, 0, 0, 0, 6'b010100, 0, st(ctl(ex("held_step_x1"), 1, 0, 1, 1, int'(ALU_AND), 1), 0, 0, 0, 11));
        cyc(0, 0, 0, 0, 6'b010100, 0, st(idle_ctl(ex("held_step_end")), 0, 1, 0, 12));

        // illegal control sub-op during STEP
        cyc(0, 0, 1, 0, 6'b000100, 0, st(idle_ctl(ex("step_ill_req")), 0, 1, 0, 12));
        e = st(idle_ctl(ex("step_illegal")), 0, 0, 0, 12);
        e.nh_pc_en = 1;
        cyc(0, 0, 0, 0, 6'b000100, 0, e);
        cyc(0, 0, 0, 0, 6'b000011, 0, st(idle_ctl(ex("step_ill_flag")), 0, 1, 1, 12));

        // illegal class 11 during RUN
        cyc(0, 1, 0, 0, 6'b000011, 0, st(idle_ctl(ex("restart_from_ill")), 0, 1, 1, 12));
        cyc(0, 0, 0, 0, 6'b000011, 0, st(ctl(ex("restart_clears"), 1, 0, 0, 0, 0, 1), 1, 0, 0, 12));
        e = st(idle_ctl(ex("run_illegal")), 1, 0, 0, 13);
        e.nh_pc_en = 1; e.nh_running = 1;
        cyc(0, 0, 0, 0, 6'b110000, 0, e);
        e = st(idle_ctl(ex("run_ill_halts")), 0, 1, 1, 13);
        e.nh_running = 1;
        cyc(0, 0, 0, 0, 6'b000011, 0, e);
        cyc(0, 1, 0, 0, 6'b000011, 0, st(idle_ctl(ex("restart2")), 0, 1, 1, 13));

        // halt_req with add, then reset mid-RUN
        cyc(0, 0, 0, 1, 6'b010010, 0, st(ctl(ex("halt_add"), 1, 0, 1, 1, int'(ALU_ADD), 1), 1, 0, 0, 13));
        cyc(0, 0, 0, 0, 6'b010010, 0, st(idle_ctl(ex("halt_add_done")), 0, 1, 0, 14));
        cyc(0, 1, 0, 0, 6'b000011, 0, st(idle_ctl(ex("restart3")), 0, 1, 0, 14));
        cyc(0, 0, 0, 0, 6'b000011, 0, st(ctl(ex("run_nop"), 1, 0, 0, 0, 0, 1), 1, 0, 0, 14));
        cyc(1, 0, 0, 0, 6'b000011, 0, st(ctl(ex("reset_in_run"), 1, 0, 0, 0, 0, 1), 1, 0, 0, 15));
        e = st(idle_ctl(ex("after_reset")), 0, 0, 0, 0);
        e.cnt4 = 0; e.nh_running = 0;
        cyc(0, 0, 0, 0, 6'b000011, 0, e);

        // 20 instructions: 16-bit counter reaches 20, 4-bit saturates at 15
        cyc(0, 1, 0, 0, 6'b000011, 0, st(idle_ctl(ex("start_run20")), 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            e = st(ctl(ex("run20"), 1, 0, 0, 0, 0, 1), 1, 0, 0, i);
            e.cnt4 = (i < 15) ? i : 15;
            cyc(0, 0, 0, 0, 6'b000011, 0, e);
        end
        e = st(ctl(ex("run20_final"), 1, 0, 0, 0, 0, 1), 1, 0, 0, 20);
        e.cnt4 = 15;
        cyc(0, 0, 0, 1, 6'b000011, 0, e);
        e = st(idle_ctl(ex("cnt_saturated")), 0, 1, 0, 21);
        e.cnt4 = 15;
        cyc(0, 0, 0, 0, 6'b000011, 0, e);

        // drain scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, want bench to finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/microc_run_ctrl.md
Name: microc_run_ctrl

Overview:
Sequencing control unit for the microc single-cycle datapath. It decodes the 6-bit Opcode and the z flag into s_inc, s_inm, we, wez and ALUOp. It gates execution through a run-control FSM (idle / run / single-step / halt) and keeps a retired-instruction counter. It sits beside microc at the top level and replaces hand-driven control from benches. microc gains one PC-enable input, driven by pc_en, in the same change.

Parameters:
CNT_W, 16, width of the retired-instruction counter.
HALT_ON_ILLEGAL, 1, 1: an illegal opcode stops the core; 0: it executes as nop.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level; request free-running execution
step  in  1  level; request execution of exactly one instruction
halt_req  in  1  level; request stop after the current instruction
Opcode  in  6  opcode of the instruction at PC, from microc
z  in  1  zero flag from microc
s_inc  out  1  PC mux select; 1 = PC+1, 0 = jump target
s_inm  out  1  register-file write mux select; 1 = immediate, 0 = ALU
we  out  1  register-file write enable
wez  out  1  zero-flag write enable
ALUOp  out  3  ALU operation code
pc_en  out  1  PC register load enable
running  out  1  FSM in RUN
halted  out  1  FSM in HALT
illegal  out  1  sticky illegal-opcode flag
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (synchronous, clk edge with reset=1) leaves:
  - state IDLE, illegal=0, instr_count=0.
  - This overrides every other input. Reset mid-RUN takes effect at that edge.
- Decode (combinational from Opcode, z), by class Opcode[5:4]:
  - 01, register ALU: ALUOp=Opcode[2:0], we=1, wez=1, s_inm=0, s_inc=1.
  - 10, immediate ALU: ALUOp=Opcode[2:0], we=1, s_inm=1, s_inc=1. wez=1 except ALUOp=000 (li), where wez=0.
  - 00, control: we=0, wez=0, s_inm=0, ALUOp=000.
    - Opcode[3:0]=0000 (j): s_inc=0.
    - 0001 (jz): s_inc=~z.
    - 0010 (jnz): s_inc=z.
    - 0011 (nop): s_inc=1.
    - Any other value is illegal.
  - 11: illegal.
- Execute cycle: state RUN, or state STEP.
  - Legal opcode: decoded outputs driven, pc_en=1.
  - Illegal opcode with HALT_ON_ILLEGAL=1: we=wez=pc_en=0, s_inc=1; illegal set at the next edge.
  - Illegal opcode with HALT_ON_ILLEGAL=0: behaves as nop.
- Non-execute cycle (IDLE, HALT): we=wez=pc_en=0, s_inc=1, s_inm=0, ALUOp=000. The PC holds.
- Output latency: outputs are combinational in the same cycle as Opcode. There are no registered outputs except the flags and counter.
- FSM transitions, evaluated on each clk edge. In IDLE and HALT, start has priority over step.
  - IDLE: start -> RUN; else step -> STEP; else stay.
  - RUN:
    - illegal opcode (HALT_ON_ILLEGAL=1) -> HALT.
    - else halt_req -> HALT. The instruction in the halt_req cycle still executes.
    - else stay.
  - STEP: -> HALT always. Exactly one instruction executes. step held high does not re-execute until it is seen again in HALT; a held step yields one instruction every 2 cycles.
    - Illegal opcode in STEP (HALT_ON_ILLEGAL=1): -> HALT with illegal set.
  - HALT: start -> RUN; else step -> STEP; else stay.
- illegal flag: cleared on reset and on any edge where start causes HALT/IDLE -> RUN.
- instr_count: +1 on every edge where pc_en=1. Saturates at all-ones.
- State encoding: 2 bits: IDLE=00, RUN=01, STEP=10, HALT=11.
- Status outputs: running=(state==RUN), halted=(state==HALT).

Decomposition:
- Shared include/package microc_defs.vh holds:
  - opcode class constants (CLS_CTRL=2'b00, CLS_REG=2'b01, CLS_IMM=2'b10);
  - control sub-ops (OP_J, OP_JZ, OP_JNZ, OP_NOP);
  - ALUOp constants (ALU_PASS=3'b000, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_AND=3'b100);
  - FSM state encodings.
- One sub-module, uc_decode: purely combinational Opcode/z to control word plus an illegal bit. The FSM, gating and counter stay in microc_run_ctrl.

Test Plan:
1. Reset, start=0 for 4 cycles, Opcode=6'b100000 -> pc_en=0, we=0, wez=0, running=0, halted=0, instr_count=0.
2. start=1 for one cycle, then Opcode 6'b100000 (li) -> we=1, s_inm=1, wez=0, ALUOp=000, pc_en=1. Then Opcode 6'b010011 (sub) -> we=1, wez=1, s_inm=0, ALUOp=011. instr_count=2.
3. In RUN:
   - jnz 6'b000010, z=0 -> s_inc=0; z=1 -> s_inc=1.
   - jz 6'b000001, z=1 -> s_inc=0.
   - j 6'b000000 -> s_inc=0.
   - All four cases: we=0, wez=0.
4. From HALT, step=1 one cycle, Opcode 6'b100010 (addi) -> exactly one cycle with pc_en=1, we=1, ALUOp=010. Then halted=1 and instr_count incremented by exactly 1.
5. In RUN, Opcode 6'b110000 -> that cycle we=wez=pc_en=0; next cycle illegal=1, halted=1. Then start=1 -> running=1, illegal=0.
6. halt_req=1 during RUN with add 6'b010010 -> add executes (pc_en=1), next cycle halted=1. Then reset=1 mid-RUN -> next cycle IDLE, instr_count=0. With CNT_W=4, 20 RUN instructions -> instr_count=15.
